scan_fsm: RTL and testbench

Pixel-scan sequencer for the speckle sensor matrix. When granted by the top-level mode FSM through `i_go`, it walks every row and column of the pixel array. For each pixel it:
- drives the row and column driver shift registers,
- strobes the key-write line,
- captures one 12-bit ADC sample and writes it to block RAM through the shared row/column address counters.

Its outputs feed the scan inputs of the top-level resource mux.

---
 rtl/scan_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_scan_fsm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_fsm.sv
// scan_fsm: pixel-scan sequencer for the speckle sensor matrix.
// Walks every row/column, shifts the one-hot row/column selects, strobes the
// key-write line, captures one ADC sample per pixel and writes it to RAM via
// the shared row/column address counter commands.
// Optional feature: define SCAN_ADC_TIMEOUT_EN to bound the ADC wait and
// substitute 12'hFFF (with a sticky error flag) when the ADC never answers.
module scan_fsm #(
    parameter int ROWS          = 24,
    parameter int COLS          = 24,
    parameter int SETTLE_CYCLES = 8,
    parameter int ADC_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_go,
    input  logic [11:0] i_adc_data,
    input  logic        i_adc_valid,
    output logic [4:0]  o_col_control,
    output logic [4:0]  o_row_control,
    output logic        o_ram_wren,
    output logic [11:0] o_ram_data,
    output logic        o_row_reg_data,
    output logic        o_row_reg_write,
    output logic        o_col_reg_data,
    output logic        o_col_reg_write,
    output logic        o_key_wren,
    output logic        o_row_rst,
    output logic        o_scan_end,
    output logic        o_timeout_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_ROW_RST, S_ROW_SHIFT, S_SETTLE, S_COL_SHIFT,
        S_ADC_WAIT, S_WRITE, S_NEXT_ROW, S_DONE
    } state_e;

    // Address counter command encoding: bit4 clear, bit3 increment.
    localparam logic [4:0] CTL_CLEAR = 5'b10000;
    localparam logic [4:0] CTL_INC   = 5'b01000;
    localparam logic [4:0] CTL_HOLD  = 5'b00000;

    localparam logic [4:0] ROW_LAST    = 5'(ROWS - 1);
    localparam logic [4:0] COL_LAST    = 5'(COLS - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] sample_q, sample_d;

`ifdef SCAN_ADC_TIMEOUT_EN
    localparam logic [7:0] ADC_LAST = 8'(ADC_TIMEOUT - 1);
    logic err_q, err_d;
`else
    logic adc_timeout_unused;
    assign adc_timeout_unused = (ADC_TIMEOUT != 0);
`endif

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
`ifdef SCAN_ADC_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
`ifdef SCAN_ADC_TIMEOUT_EN
            err_q    <= err_d;
`endif
        end
    end

    // Next-state logic: scan sequencing, settle/ADC counting, abort on i_go low.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
`ifdef SCAN_ADC_TIMEOUT_EN
        err_d    = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_go) begin
                    state_d = S_ROW_RST;
                    row_d   = '0;
                    col_d   = '0;
`ifdef SCAN_ADC_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_ROW_RST: state_d = S_ROW_SHIFT;
            S_ROW_SHIFT: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = S_COL_SHIFT;
                else                      cnt_d   = cnt_q + 8'd1;
            end
            S_COL_SHIFT: begin
                cnt_d   = '0;
                state_d = S_ADC_WAIT;
            end
            S_ADC_WAIT: begin
                if (i_adc_valid) begin
                    sample_d = i_adc_data;
                    state_d  = S_WRITE;
                end
`ifdef SCAN_ADC_TIMEOUT_EN
                else if (cnt_q == ADC_LAST) begin
                    sample_d = 12'hFFF;
                    err_d    = 1'b1;
                    state_d  = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_WRITE: begin
                if (col_q == COL_LAST) begin
                    state_d = S_NEXT_ROW;
                end else begin
                    col_d   = col_q + 5'd1;
                    state_d = S_COL_SHIFT;
                end
            end
            S_NEXT_ROW: begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = row_q + 5'd1;
                    state_d = S_ROW_SHIFT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Losing the grant mid-scan freezes the datapath and returns to IDLE.
        if (!i_go && state_q != S_IDLE && state_q != S_DONE) begin
            state_d  = S_IDLE;
            row_d    = row_q;
            col_d    = col_q;
            cnt_d    = cnt_q;
            sample_d = sample_q;
`ifdef SCAN_ADC_TIMEOUT_EN
            err_d    = err_q;
`endif
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        o_col_control   = CTL_HOLD;
        o_row_control   = CTL_HOLD;
        o_ram_wren      = 1'b0;
        o_row_reg_data  = 1'b0;
        o_row_reg_write = 1'b0;
        o_col_reg_data  = 1'b0;
        o_col_reg_write = 1'b0;
        o_key_wren      = 1'b0;
        o_row_rst       = 1'b0;
        o_scan_end      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                o_col_control = CTL_CLEAR;
                o_row_control = CTL_CLEAR;
            end
            S_ROW_RST: begin
                o_row_rst     = 1'b1;
                o_col_control = CTL_CLEAR;
                o_row_control = CTL_CLEAR;
            end
            S_ROW_SHIFT: begin
                o_row_reg_write = 1'b1;
                o_row_reg_data  = (row_q == 5'd0);
            end
            S_COL_SHIFT: begin
                o_col_reg_write = 1'b1;
                o_col_reg_data  = (col_q == 5'd0);
                o_key_wren      = 1'b1;
            end
            S_WRITE: begin
                o_ram_wren    = 1'b1;
                o_col_control = CTL_INC;
            end
            S_NEXT_ROW: begin
                o_row_control = CTL_INC;
                o_col_control = CTL_CLEAR;
            end
            S_DONE:  o_scan_end = 1'b1;
            default: ;
        endcase
    end

    assign o_ram_data = sample_q;

`ifdef SCAN_ADC_TIMEOUT_EN
    assign o_timeout_err = err_q;
`else
    assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_scan_fsm.sv
// tb_scan_fsm: directed vector table plus hand-written multi-cycle sequences
// for scan_fsm configured as a 4x4 matrix with a 2-clock settle delay.
module tb_scan_fsm;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int SETTLE = 2;
    localparam int ADC_TO = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_go;
    logic [11:0] i_adc_data;
    logic        i_adc_valid;
    logic [4:0]  o_col_control, o_row_control;
    logic        o_ram_wren;
    logic [11:0] o_ram_data;
    logic        o_row_reg_data, o_row_reg_write, o_col_reg_data, o_col_reg_write;
    logic        o_key_wren, o_row_rst, o_scan_end, o_timeout_err;

    scan_fsm #(.ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE), .ADC_TIMEOUT(ADC_TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_adc_data(i_adc_data),
        .i_adc_valid(i_adc_valid), .o_col_control(o_col_control),
        .o_row_control(o_row_control), .o_ram_wren(o_ram_wren), .o_ram_data(o_ram_data),
        .o_row_reg_data(o_row_reg_data), .o_row_reg_write(o_row_reg_write),
        .o_col_reg_data(o_col_reg_data), .o_col_reg_write(o_col_reg_write),
        .o_key_wren(o_key_wren), .o_row_rst(o_row_rst), .o_scan_end(o_scan_end),
        .o_timeout_err(o_timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        go;
        logic        valid;
        logic [11:0] data;
        logic [4:0]  col_ctl;
        logic [4:0]  row_ctl;
        logic [7:0]  flags;  // row_rst,row_wr,row_dat,col_wr,col_dat,key,wren,scan_end
        logic [11:0] ram;
    } vec_t;

    int total = 0;
    int bad = 0;

    // Scan statistics gathered by step().
    int cyc, wr_cnt, row_wr_cnt, row_ones, col_wr_cnt, col_dat_bad, key_cnt;
    int end_cnt, end_cyc, key3_cyc, wr3_cyc, drop_pixel;
    bit auto_adc;
    logic [11:0] wr_data [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {2'b00, o_col_control, o_row_control, o_row_rst, o_row_reg_write,
                o_row_reg_data, o_col_reg_write, o_col_reg_data, o_key_wren,
                o_ram_wren, o_scan_end, o_ram_data};
    endfunction

    task automatic clear_stats();
        cyc = 0; wr_cnt = 0; row_wr_cnt = 0; row_ones = 0; col_wr_cnt = 0;
        col_dat_bad = 0; key_cnt = 0; end_cnt = 0; end_cyc = -1;
        key3_cyc = -1; wr3_cyc = -1;
    endtask

    // One clock: sample outputs 1ns after the edge, then drive the ADC model.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (o_ram_wren) begin
            if (wr_cnt == 3) wr3_cyc = cyc;
            if (wr_cnt < 64) wr_data[wr_cnt] = o_ram_data;
            wr_cnt++;
        end
        if (o_row_reg_write) begin
            if (o_row_reg_data) row_ones++;
            row_wr_cnt++;
        end
        if (o_col_reg_write) begin
            if (o_col_reg_data != ((col_wr_cnt % COLS) == 0)) col_dat_bad++;
            col_wr_cnt++;
        end
        if (o_key_wren) begin
            if (key_cnt == 3) key3_cyc = cyc;
            key_cnt++;
        end
        if (o_scan_end) begin
            end_cnt++;
            if (end_cyc < 0) end_cyc = cyc;
        end
        if (auto_adc) begin
            i_adc_data  = 12'(wr_cnt);
            i_adc_valid = (drop_pixel != wr_cnt);
        end
    endtask

    task automatic run_to_end(input int budget);
        while (end_cyc < 0 && cyc < budget) step();
    endtask

    localparam logic [31:0] RESET_OUTS = {2'b00, 5'h10, 5'h10, 8'h00, 12'h000};

    vec_t vecs [13];

    initial begin
        rst_n = 1'b0; i_go = 1'b0; i_adc_valid = 1'b0; i_adc_data = '0;
        auto_adc = 1'b0; drop_pixel = -1;
        clear_stats();

        // Reset state
        #12;
        check("reset_outs", outs(), RESET_OUTS);
        check("reset_err", 32'(o_timeout_err), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed vectors: outputs expected after the edge that sees the inputs.
        //          go  vld data     col    row    flags        ram
        vecs[0]  = '{1, 0, 12'h000, 5'h10, 5'h10, 8'b1000_0000, 12'h000}; // ROW_RST
        vecs[1]  = '{1, 0, 12'h000, 5'h00, 5'h00, 8'b0110_0000, 12'h000}; // ROW_SHIFT row0
        vecs[2]  = '{1, 1, 12'h777, 5'h00, 5'h00, 8'b0000_0000, 12'h000}; // SETTLE
        vecs[3]  = '{1, 1, 12'h777, 5'h00, 5'h00, 8'b0000_0000, 12'h000}; // SETTLE, valid ignored
        vecs[4]  = '{1, 1, 12'h777, 5'h00, 5'h00, 8'b0001_1100, 12'h000}; // COL_SHIFT col0
        vecs[5]  = '{1, 1, 12'h777, 5'h00, 5'h00, 8'b0000_0000, 12'h000}; // ADC_WAIT
        vecs[6]  = '{1, 0, 12'h000, 5'h00, 5'h00, 8'b0000_0000, 12'h000}; // ADC_WAIT held
        vecs[7]  = '{1, 1, 12'hABC, 5'h08, 5'h00, 8'b0000_0010, 12'hABC}; // WRITE
        vecs[8]  = '{1, 0, 12'h000, 5'h00, 5'h00, 8'b0001_0100, 12'hABC}; // COL_SHIFT col1
        vecs[9]  = '{1, 1, 12'h123, 5'h00, 5'h00, 8'b0000_0000, 12'hABC}; // ADC_WAIT
        vecs[10] = '{1, 1, 12'h456, 5'h08, 5'h00, 8'b0000_0010, 12'h456}; // WRITE
        vecs[11] = '{0, 0, 12'h000, 5'h10, 5'h10, 8'b0000_0000, 12'h456}; // abort -> IDLE
        vecs[12] = '{0, 1, 12'h999, 5'h10, 5'h10, 8'b0000_0000, 12'h456}; // IDLE, valid ignored
        for (int i = 0; i < 13; i++) begin
            i_go = vecs[i].go; i_adc_valid = vecs[i].valid; i_adc_data = vecs[i].data;
            step();
            check($sformatf("vec%0d", i), outs(),
                  {2'b00, vecs[i].col_ctl, vecs[i].row_ctl, vecs[i].flags, vecs[i].ram});
        end

        // Full scan: data = pixel index, valid held high.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        clear_stats();
        auto_adc = 1'b1; i_adc_valid = 1'b1; i_adc_data = '0; i_go = 1'b1;
        run_to_end(300);
        check("scan_end_cycle", 32'(end_cyc), 32'd66);
        check("scan_writes", 32'(wr_cnt), 32'd16);
        check("row_shifts", 32'(row_wr_cnt), 32'd4);
        check("row_data_ones", 32'(row_ones), 32'd1);
        check("col_shifts", 32'(col_wr_cnt), 32'd16);
        check("col_data_pattern", 32'(col_dat_bad), 32'd0);
        for (int i = 0; i < 16; i++) check($sformatf("ram_data%0d", i), 32'(wr_data[i]), 32'(i));
        step();
        check("post_done_idle", {27'd0, o_scan_end, o_col_control}, {27'd0, 1'b0, 5'h10});
        check("scan_end_count", 32'(end_cnt), 32'd1);
        step();
        check("restart_row_rst", 32'(o_row_rst), 32'd1);
        i_go = 1'b0;
        step();
        check("stop_idle", outs(), {2'b00, 5'h10, 5'h10, 8'h00, 12'd15});

        // Abort during row 2 ADC_WAIT.
        clear_stats();
        i_go = 1'b1;
        while (!(row_wr_cnt == 3 && o_key_wren) && cyc < 300) step();
        check("abort_reached", 32'(wr_cnt), 32'd8);
        step();
        i_go = 1'b0;
        step();
        check("abort_idle", outs(), {2'b00, 5'h10, 5'h10, 8'h00, 12'd7});
        for (int i = 0; i < 30; i++) step();
        check("abort_no_writes", 32'(wr_cnt), 32'd8);
        check("abort_no_end", 32'(end_cnt), 32'd0);

        // Reset pulsed in row 1 SETTLE, then a full restart.
        clear_stats();
        i_go = 1'b1;
        while (!(row_wr_cnt == 2 && o_row_reg_write) && cyc < 300) step();
        step();
        rst_n = 1'b0;
        #1;
        check("midreset_outs", outs(), RESET_OUTS);
        check("midreset_err", 32'(o_timeout_err), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        clear_stats();
        run_to_end(300);
        check("restart_end_cycle", 32'(end_cyc), 32'd66);
        check("restart_writes", 32'(wr_cnt), 32'd16);
        i_go = 1'b0;
        step(); step();

`ifdef SCAN_ADC_TIMEOUT_EN
        // Pixel 3 never gets a valid strobe.
        clear_stats();
        drop_pixel = 3;
        i_go = 1'b1;
        run_to_end(300);
        check("to_wait_len", 32'(wr3_cyc - key3_cyc), 32'(ADC_TO + 1));
        check("to_data", 32'(wr_data[3]), 32'hFFF);
        check("to_next_data", 32'(wr_data[4]), 32'd4);
        check("to_writes", 32'(wr_cnt), 32'd16);
        check("to_end_cycle", 32'(end_cyc), 32'(66 + ADC_TO - 1));
        check("to_err_set", 32'(o_timeout_err), 32'd1);
        drop_pixel = -1;
        step();
        check("to_err_sticky", 32'(o_timeout_err), 32'd1);
        step();
        check("to_err_cleared", {30'd0, o_row_rst, o_timeout_err}, {30'd0, 1'b1, 1'b0});
        i_go = 1'b0;
        step();
`else
        check("err_tied_low", 32'(o_timeout_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
